// File: rtl/match_scorer.sv
// Two-player match scorer: serve countdown, goal detection,
// saturating scores and win-by-margin evaluation.

module match_scorer #(
    parameter int BALL_X_W    = 10,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int SCORE_W     = 7,
    parameter int SCORE_MAX   = 99,
    parameter int WIN_SCORE   = 11,
    parameter int WIN_BY_TWO  = 1,
    parameter int SERVE_DELAY = 60
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       frame_tick,
    input  logic                       ball_valid,
    input  logic signed [BALL_X_W-1:0] ball_x,
    output logic [SCORE_W-1:0]         score1,
    output logic [SCORE_W-1:0]         score2,
    output logic [1:0]                 point_pulse,
    output logic                       serve_req,
    output logic                       serve_dir,
    output logic                       game_over,
    output logic [1:0]                 winner,
    output logic [1:0]                 state
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam int SW1   = SCORE_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [SCORE_W-1:0] S_MAX    = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] S_ONE    = SCORE_W'(1);
    localparam logic [SW1-1:0]     WIN_T    = SW1'(WIN_SCORE);
    localparam logic [SW1-1:0]     LEAD     = SW1'((WIN_BY_TWO != 0) ? 2 : 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] s2_q, s2_d;
    logic [1:0]         pp_q, pp_d;
    logic               dir_q, dir_d;
    logic [1:0]         win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    int                 bx;
    logic               goal_p1;
    logic               goal_p2;
    logic               sample;
    logic               tick_ok;
    logic [SCORE_W-1:0] inc1;
    logic [SCORE_W-1:0] inc2;
    logic [SW1-1:0]     p1_new;
    logic [SW1-1:0]     p1_opp;
    logic [SW1-1:0]     p2_new;
    logic [SW1-1:0]     p2_opp;
    logic               p1_wins;
    logic               p2_wins;

    // Goal detection: signed compare of the sign-extended ball position.
    always_comb begin
        bx      = int'(ball_x);
        goal_p1 = (bx < X_MIN);
        goal_p2 = (bx > X_MAX);
        sample  = (fsm_q == PLAY) && frame_tick && ball_valid;
        // A tick landing on the point_pulse cycle is not counted, so
        // point_pulse and serve_req can never coincide.
        tick_ok = (fsm_q == SERVE) && frame_tick && (pp_q == 2'b00);
    end

    // Post-increment scores and the win test against the opponent.
    always_comb begin
        inc1    = (s1_q >= S_MAX) ? S_MAX : s1_q + S_ONE;
        inc2    = (s2_q >= S_MAX) ? S_MAX : s2_q + S_ONE;
        p1_new  = {1'b0, inc1};
        p1_opp  = {1'b0, s2_q};
        p2_new  = {1'b0, inc2};
        p2_opp  = {1'b0, s1_q};
        p1_wins = (p1_new >= WIN_T) && (p1_new > p1_opp) &&
                  ((p1_new - p1_opp) >= LEAD);
        p2_wins = (p2_new >= WIN_T) && (p2_new > p2_opp) &&
                  ((p2_new - p2_opp) >= LEAD);
    end

    // Next-state and datapath updates; start overrides everything.
    always_comb begin
        fsm_d     = fsm_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        pp_d      = 2'b00;
        dir_d     = dir_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        serve_req = 1'b0;
        if (start) begin
            fsm_d = SERVE;
            s1_d  = '0;
            s2_d  = '0;
            dir_d = 1'b0;
            win_d = 2'b00;
            cnt_d = CNT_LOAD;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                end
                SERVE: begin
                    if (tick_ok) begin
                        if (cnt_q <= CNT_ONE) begin
                            cnt_d     = '0;
                            serve_req = 1'b1;
                            fsm_d     = PLAY;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
                PLAY: begin
                    if (sample && goal_p1) begin
                        pp_d  = 2'b01;
                        s1_d  = inc1;
                        dir_d = 1'b1;
                        cnt_d = CNT_LOAD;
                        if (p1_wins) begin
                            fsm_d = OVER;
                            win_d = 2'b01;
                        end else begin
                            fsm_d = SERVE;
                        end
                    end else if (sample && goal_p2) begin
                        pp_d  = 2'b10;
                        s2_d  = inc2;
                        dir_d = 1'b0;
                        cnt_d = CNT_LOAD;
                        if (p2_wins) begin
                            fsm_d = OVER;
                            win_d = 2'b10;
                        end else begin
                            fsm_d = SERVE;
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                end
            endcase
        end
    end

    // State, scores, pulse and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q <= IDLE;
            s1_q  <= '0;
            s2_q  <= '0;
            pp_q  <= 2'b00;
            dir_q <= 1'b0;
            win_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            pp_q  <= pp_d;
            dir_q <= dir_d;
            win_q <= win_d;
            cnt_q <= cnt_d;
        end
    end

    assign score1      = s1_q;
    assign score2      = s2_q;
    assign point_pulse = pp_q;
    assign serve_dir   = dir_q;
    assign game_over   = (fsm_q == OVER);
    assign winner      = win_q;
    assign state       = fsm_q;

endmodule

// File: tb/tb_match_scorer.sv
// Directed bench for match_scorer: two instances share stimulus,
// A wins-by-two (delay 3, max 12), B wins-by-one (delay 12).

module tb_match_scorer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic signed [10:0] BX_L = -11'sd5;
    localparam logic signed [10:0] BX_R = 11'sd700;
    localparam logic signed [10:0] BX_C = 11'sd0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic frame_tick = 1'b0;
    logic ball_valid = 1'b0;
    logic signed [10:0] ball_x = '0;

    logic [6:0] score1_a, score2_a, score1_b, score2_b;
    logic [1:0] point_a, point_b, winner_a, winner_b, state_a, state_b;
    logic       sreq_out_a, sreq_out_b, dir_a, dir_b, over_a, over_b;

    int checks = 0;
    int failures = 0;
    int n1_a = 0, n2_a = 0, ns_a = 0;
    int n1_b = 0, n2_b = 0, ns_b = 0;
    int clash = 0;
    logic sreq_a = 1'b0;

    match_scorer #(
        .BALL_X_W(11), .SCORE_MAX(12), .WIN_BY_TWO(1), .SERVE_DELAY(3)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .frame_tick(frame_tick), .ball_valid(ball_valid),
        .ball_x(ball_x), .score1(score1_a), .score2(score2_a),
        .point_pulse(point_a), .serve_req(sreq_out_a),
        .serve_dir(dir_a), .game_over(over_a),
        .winner(winner_a), .state(state_a)
    );

    match_scorer #(
        .BALL_X_W(11), .WIN_BY_TWO(0), .SERVE_DELAY(12)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .frame_tick(frame_tick), .ball_valid(ball_valid),
        .ball_x(ball_x), .score1(score1_b), .score2(score2_b),
        .point_pulse(point_b), .serve_req(sreq_out_b),
        .serve_dir(dir_b), .game_over(over_b),
        .winner(winner_b), .state(state_b)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (point_a == 2'b01) n1_a++;
        if (point_a == 2'b10) n2_a++;
        if (sreq_out_a) ns_a++;
        if (point_b == 2'b01) n1_b++;
        if (point_b == 2'b10) n2_b++;
        if (sreq_out_b) ns_b++;
        if ((point_a != 2'b00 && sreq_out_a) || point_a == 2'b11) clash++;
        if ((point_b != 2'b00 && sreq_out_b) || point_b == 2'b11) clash++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; called and returns at posedge+1.
    task automatic step(input logic st, input logic ft, input logic bv,
                        input logic signed [10:0] bx);
        start = st;
        frame_tick = ft;
        ball_valid = bv;
        ball_x = bx;
        @(negedge clk);
        sreq_a = sreq_out_a;
        @(posedge clk);
        #1;
        start = 1'b0;
        frame_tick = 1'b0;
        ball_valid = 1'b0;
        ball_x = BX_C;
    endtask

    task automatic serve_both();
        repeat (12) step(L, H, L, BX_C);
    endtask

    task automatic point(input int p);
        step(L, H, H, (p == 1) ? BX_L : BX_R);
        step(L, L, L, BX_C);
    endtask

    task automatic rally(input int p);
        point(p);
        serve_both();
    endtask

    task automatic to_ten();
        step(H, L, L, BX_C);
        serve_both();
        for (int i = 0; i < 10; i++) begin
            rally(1);
            rally(2);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (state_a !== 2'd0 || state_b !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=0", state_a, state_b);
        end
        checks++;
        if (score1_a !== 7'd0 || score2_a !== 7'd0 || point_a !== 2'b00 ||
            sreq_out_a !== 1'b0 || dir_a !== 1'b0 || over_a !== 1'b0 ||
            winner_a !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs got=%0d %0d %0d %0d %0d %0d %0d exp=all0",
                     score1_a, score2_a, point_a, sreq_out_a, dir_a, over_a, winner_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(L, H, H, BX_L);
        checks++;
        if (state_a !== 2'd0 || n1_a !== 0) begin
            failures++;
            $display("FAIL idle_ignores_goal got=%0d/%0d exp=0/0", state_a, n1_a);
        end
    endtask

    task automatic test_serve();
        step(H, L, L, BX_C);
        checks++;
        if (state_a !== 2'd1 || score1_a !== 7'd0) begin
            failures++;
            $display("FAIL start_to_serve got=%0d exp=1", state_a);
        end
        step(L, H, L, BX_C);
        checks++;
        if (sreq_a !== 1'b0) begin
            failures++;
            $display("FAIL serve_tick1 got=%0d exp=0", sreq_a);
        end
        step(L, H, L, BX_C);
        checks++;
        if (sreq_a !== 1'b0) begin
            failures++;
            $display("FAIL serve_tick2 got=%0d exp=0", sreq_a);
        end
        step(L, H, L, BX_C);
        checks++;
        if (sreq_a !== 1'b1 || dir_a !== 1'b0) begin
            failures++;
            $display("FAIL serve_tick3 got=%0d dir=%0d exp=1 dir=0", sreq_a, dir_a);
        end
        checks++;
        if (state_a !== 2'd2) begin
            failures++;
            $display("FAIL serve_to_play got=%0d exp=2", state_a);
        end
        repeat (9) step(L, H, L, BX_C);
        checks++;
        if (state_b !== 2'd2 || ns_b !== 1) begin
            failures++;
            $display("FAIL b_serve_delay12 got=%0d/%0d exp=2/1", state_b, ns_b);
        end
    endtask

    task automatic test_hold();
        int n1b0, n2b0;
        n1b0 = n1_b;
        n2b0 = n2_b;
        repeat (10) step(L, H, H, BX_L);
        step(L, L, L, BX_C);
        checks++;
        if (n1_b - n1b0 !== 1 || n2_b - n2b0 !== 0) begin
            failures++;
            $display("FAIL hold_one_point got=%0d exp=1", n1_b - n1b0);
        end
        checks++;
        if (score1_b !== 7'd1 || dir_b !== 1'b1 || state_b !== 2'd1) begin
            failures++;
            $display("FAIL hold_after got=%0d dir=%0d st=%0d exp=1 1 1",
                     score1_b, dir_b, state_b);
        end
        checks++;
        if (score1_a !== 7'd2 || state_a !== 2'd2) begin
            failures++;
            $display("FAIL a_reserve_hold got=%0d st=%0d exp=2 2", score1_a, state_a);
        end
        serve_both();
    endtask

    task automatic test_win_by_two();
        int ns0;
        to_ten();
        checks++;
        if (score1_a !== 7'd10 || score2_a !== 7'd10 || state_a !== 2'd2) begin
            failures++;
            $display("FAIL ten_all got=%0d-%0d st=%0d exp=10-10 2",
                     score1_a, score2_a, state_a);
        end
        point(1);
        checks++;
        if (score1_a !== 7'd11 || over_a !== 1'b0 || state_a !== 2'd1) begin
            failures++;
            $display("FAIL a_11_10 got=%0d over=%0d exp=11 0", score1_a, over_a);
        end
        checks++;
        if (over_b !== 1'b1 || winner_b !== 2'b01 || state_b !== 2'd3) begin
            failures++;
            $display("FAIL b_win_11_10 got=%0d w=%0d exp=1 1", over_b, winner_b);
        end
        serve_both();
        step(L, H, H, BX_L);
        checks++;
        if (point_a !== 2'b01 || score1_a !== 7'd12) begin
            failures++;
            $display("FAIL a_12_10 got=%0d pp=%0d exp=12 1", score1_a, point_a);
        end
        checks++;
        if (over_a !== 1'b1 || winner_a !== 2'b01 || state_a !== 2'd3) begin
            failures++;
            $display("FAIL a_win got=%0d w=%0d exp=1 1", over_a, winner_a);
        end
        ns0 = ns_a;
        step(L, L, L, BX_C);
        repeat (5) step(L, H, H, BX_R);
        checks++;
        if (ns_a !== ns0 || score2_a !== 7'd10 || winner_a !== 2'b01 ||
            score1_b !== 7'd11) begin
            failures++;
            $display("FAIL over_frozen got=%0d %0d %0d exp=%0d 10 1",
                     ns_a, score2_a, winner_a, ns0);
        end
    endtask

    task automatic test_win_by_one();
        int nsa0, nsb0;
        to_ten();
        nsa0 = ns_a;
        nsb0 = ns_b;
        step(L, H, H, BX_R);
        checks++;
        if (score2_b !== 7'd11 || over_b !== 1'b1 || winner_b !== 2'b10) begin
            failures++;
            $display("FAIL b_p2_win got=%0d over=%0d w=%0d exp=11 1 2",
                     score2_b, over_b, winner_b);
        end
        checks++;
        if (score2_a !== 7'd11 || over_a !== 1'b0 || point_a !== 2'b10 ||
            dir_a !== 1'b0) begin
            failures++;
            $display("FAIL a_p2_nowin got=%0d over=%0d exp=11 0", score2_a, over_a);
        end
        step(L, L, L, BX_C);
        serve_both();
        checks++;
        if (ns_b - nsb0 !== 0 || ns_a - nsa0 !== 1) begin
            failures++;
            $display("FAIL serve_after_win got=%0d/%0d exp=0/1",
                     ns_b - nsb0, ns_a - nsa0);
        end
    endtask

    task automatic test_saturate();
        to_ten();
        rally(1);
        rally(2);
        rally(1);
        rally(2);
        checks++;
        if (score1_a !== 7'd12 || score2_a !== 7'd12 || over_a !== 1'b0) begin
            failures++;
            $display("FAIL deuce_12 got=%0d-%0d exp=12-12", score1_a, score2_a);
        end
        step(L, H, H, BX_L);
        checks++;
        if (point_a !== 2'b01 || score1_a !== 7'd12 || state_a !== 2'd1 ||
            over_a !== 1'b0) begin
            failures++;
            $display("FAIL saturate got=%0d pp=%0d st=%0d exp=12 1 1",
                     score1_a, point_a, state_a);
        end
        step(L, L, L, BX_C);
        serve_both();
    endtask

    task automatic test_start_priority();
        int n0;
        n0 = n1_a;
        step(H, H, H, BX_L);
        checks++;
        if (score1_a !== 7'd0 || score2_a !== 7'd0 || point_a !== 2'b00 ||
            state_a !== 2'd1) begin
            failures++;
            $display("FAIL start_vs_goal got=%0d-%0d pp=%0d st=%0d exp=0-0 0 1",
                     score1_a, score2_a, point_a, state_a);
        end
        step(L, H, L, BX_C);
        checks++;
        if (n1_a !== n0) begin
            failures++;
            $display("FAIL start_vs_goal_pulse got=%0d exp=%0d", n1_a, n0);
        end
        step(L, H, L, BX_C);
        step(H, H, L, BX_C);
        checks++;
        if (sreq_a !== 1'b0 || state_a !== 2'd1) begin
            failures++;
            $display("FAIL start_vs_serve got=%0d st=%0d exp=0 1", sreq_a, state_a);
        end
    endtask

    task automatic test_reset_mid();
        int ns0;
        step(H, L, L, BX_C);
        serve_both();
        rally(1);
        rally(2);
        rally(1);
        rally(2);
        rally(1);
        rally(2);
        rally(1);
        point(1);
        checks++;
        if (score1_a !== 7'd5 || score2_a !== 7'd3 || state_a !== 2'd1 ||
            dir_a !== 1'b1) begin
            failures++;
            $display("FAIL reach_5_3 got=%0d-%0d st=%0d exp=5-3 1",
                     score1_a, score2_a, state_a);
        end
        step(L, H, L, BX_C);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state_a !== 2'd0 || score1_a !== 7'd0 || score2_a !== 7'd0 ||
            point_a !== 2'b00 || sreq_out_a !== 1'b0 || dir_a !== 1'b0 ||
            over_a !== 1'b0 || winner_a !== 2'b00) begin
            failures++;
            $display("FAIL async_reset got=%0d %0d-%0d dir=%0d exp=0 0-0 0",
                     state_a, score1_a, score2_a, dir_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        ns0 = ns_a;
        repeat (5) step(L, H, H, BX_L);
        checks++;
        if (ns_a !== ns0 || state_a !== 2'd0 || score1_a !== 7'd0) begin
            failures++;
            $display("FAIL reset_release_idle got=%0d st=%0d exp=%0d 0",
                     ns_a, state_a, ns0);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_hold();
        test_win_by_two();
        test_win_by_one();
        test_saturate();
        test_start_priority();
        test_reset_mid();
        checks++;
        if (clash !== 0) begin
            failures++;
            $display("FAIL pulse_exclusive got=%0d exp=0", clash);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_scorer.md
MATCH_SCORER -- requirements
Module: match_scorer

Interface
REQ-001 Parameter BALL_X_W, 10, width of signed two's-complement ball X coordinate.
REQ-002 Parameter X_MIN, 0, leftmost in-bounds X (signed).
REQ-003 Parameter X_MAX, 639, rightmost in-bounds X (signed).
REQ-004 Parameter SCORE_W, 7, score register width.
REQ-005 Parameter SCORE_MAX, 99, score saturation value; SHALL be ≤ 2^SCORE_W-1.
REQ-006 Parameter WIN_SCORE, 11, points needed to win; SHALL be ≤ SCORE_MAX.
REQ-007 Parameter WIN_BY_TWO, 1, 1 = winner must lead by ≥2, 0 = lead ≥1.
REQ-008 Parameter SERVE_DELAY, 60, frame ticks between entering SERVE and serve_req; SHALL be ≥1.
REQ-009 clk  input  1  single clock; all logic on posedge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 start  input  1  one-cycle pulse: begin new match.
REQ-012 frame_tick  input  1  one-cycle strobe per video frame; ball sampling and serve countdown.
REQ-013 ball_valid  input  1  ball_x is meaningful this cycle.
REQ-014 ball_x  input  BALL_X_W  signed ball X coordinate.
REQ-015 score1  output  SCORE_W  player-1 score.
REQ-016 score2  output  SCORE_W  player-2 score.
REQ-017 point_pulse  output  2  one-cycle pulse: 01 P1 scored, 10 P2 scored, never 11.
REQ-018 serve_req  output  1  one-cycle pulse: engine re-centres and launches ball.
REQ-019 serve_dir  output  1  launch direction with serve_req: 0 toward P1, 1 toward P2.
REQ-020 game_over  output  1  high while in OVER state.
REQ-021 winner  output  2  01 P1, 10 P2, 00 none; valid while game_over.
REQ-022 state  output  2  current FSM state encoding: IDLE=0, SERVE=1, PLAY=2, OVER=3.

Function
REQ-023 FSM states SHALL be IDLE, SERVE, PLAY, OVER.
REQ-024 IDLE: hold scores; start -> SERVE, scores cleared to 0, serve_dir=0, serve counter loaded with SERVE_DELAY.
REQ-025 SERVE: counter decrements on each frame_tick; on the tick reaching 0, serve_req pulses that same cycle and FSM -> PLAY next cycle; ball_x ignored in SERVE.
REQ-026 PLAY: goal evaluated only in cycles with frame_tick=1 and ball_valid=1, using signed comparison.
REQ-027 ball_x < X_MIN -> P1 point; ball_x > X_MAX -> P2 point; in-range -> no action.
REQ-028 On a point: point_pulse asserted the following cycle, scorer's register +1 unless already SCORE_MAX (saturate, pulse still issued), serve_dir set toward the conceding player, counter reloaded, FSM -> SERVE or OVER.
REQ-029 Exactly one point per exit; no further points until the next PLAY entry.
REQ-030 Win check uses post-increment scores: scorer ≥ WIN_SCORE and lead ≥ (WIN_BY_TWO ? 2 : 1) -> OVER, winner set, no serve.
REQ-031 If a score saturates at SCORE_MAX without satisfying REQ-030, play continues; the saturated score SHALL remain SCORE_MAX.
REQ-032 OVER: scores and winner frozen, game_over=1; only start leaves (-> SERVE, per REQ-024).
REQ-033 start in any state SHALL take priority over a same-cycle goal or serve event: scores cleared, no point_pulse, no serve_req.
REQ-034 point_pulse and serve_req SHALL never be asserted in the same cycle.
REQ-035 Latency: goal sample to point_pulse/score update = 1 cycle; final SERVE tick to serve_req = 0 cycles (combinational in that tick cycle, registered state).

Reset
REQ-036 reset low SHALL asynchronously force state=IDLE, score1=score2=0, point_pulse=00, serve_req=0, serve_dir=0, game_over=0, winner=00, serve counter=0.
REQ-037 Reset deasserted mid-match SHALL leave block in IDLE until next start; no spurious pulses on deassertion.

Verification
REQ-038 start, SERVE_DELAY=3, three frame_ticks -> serve_req on 3rd tick, state=PLAY next cycle, serve_dir=0.
REQ-039 PLAY, ball_x=-5 held 10 frame_ticks -> exactly one point_pulse=01, score1=1, serve_dir=1, state=SERVE.
REQ-040 WIN_SCORE=11, WIN_BY_TWO=1, scores 10-10, P1 point -> 11-10 no OVER; P1 point -> 12-10, game_over=1, winner=01.
REQ-041 WIN_BY_TWO=0, score2=10, P2 point (ball_x=700) -> score2=11, game_over=1, winner=10, no serve_req.
REQ-042 start and out-of-bounds ball_x in same frame_tick cycle -> scores 0-0, no point_pulse, state=SERVE.
REQ-043 Reset asserted during SERVE countdown at 5-3 -> immediately all outputs at reset values; release -> IDLE, no serve_req.
